// File: rtl/booth_pkg.sv
// Shared types and defaults for the BoothMultiplier host sequencer.
// Optional WAIT timeout is enabled by defining BOOTH_HOST_TIMEOUT_EN.
package booth_pkg;

  localparam int W_DEFAULT              = 6;
  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_X,
    LOAD_Y,
    WAIT,
    RD_HI,
    RD_LO,
    RESP
  } state_t;

endpackage

// File: rtl/booth_bus_host_if.sv
// Operand/result handshakes plus the narrow multiplier bus, bundled for booth_bus_host.
// res_err exists only when BOOTH_HOST_TIMEOUT_EN is defined.
interface booth_bus_host_if import booth_pkg::*; #(
  parameter int W = W_DEFAULT
);

  logic           op_valid;
  logic           op_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] res_data;
`ifdef BOOTH_HOST_TIMEOUT_EN
  logic           res_err;
`endif
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_in_bus;
  logic           mul_done;
  logic [W-1:0]   mul_out_bus;

  // slave is the host sequencer's view; master is the surrounding system.
  modport slave (
    input  op_valid, op_a, op_b, res_ready, mul_done, mul_out_bus,
`ifdef BOOTH_HOST_TIMEOUT_EN
    output res_err,
`endif
    output op_ready, res_valid, res_data, busy, mul_start, mul_in_bus
  );

  modport master (
    output op_valid, op_a, op_b, res_ready, mul_done, mul_out_bus,
`ifdef BOOTH_HOST_TIMEOUT_EN
    input  res_err,
`endif
    input  op_ready, res_valid, res_data, busy, mul_start, mul_in_bus
  );

endinterface

// File: rtl/booth_bus_host_timer.sv
// WAIT-state watchdog: counts consecutive cycles with run high, restarting whenever run drops.
// Only instantiated when BOOTH_HOST_TIMEOUT_EN is defined.
module booth_bus_host_timer import booth_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count_reg;

  // expired flags the TIMEOUT_CYCLES-th consecutive run cycle
  assign expired = run && (count_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      count_reg <= '0;
    end else if (!expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/booth_bus_host.sv
// Host sequencer for BoothMultiplier: serialises start/X/Y onto inBus, reads {hi,lo} from outBus.
// Define BOOTH_HOST_TIMEOUT_EN to bound the WAIT state and report res_err.
module booth_bus_host import booth_pkg::*; #(
  parameter int W              = W_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  booth_bus_host_if.slave bus
);

  state_t         state_reg;
  logic [W-1:0]   x_reg;
  logic [W-1:0]   y_reg;
  logic           mul_start_reg;
  logic [W-1:0]   mul_in_bus_reg;
  logic           res_valid_reg;
  logic [2*W-1:0] res_data_reg;
  logic           timeout;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef BOOTH_HOST_TIMEOUT_EN
  logic res_err_reg;

  booth_bus_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state_reg == WAIT),
    .expired(timeout)
  );

  assign bus.res_err = res_err_reg;
`else
  assign timeout = 1'b0;
`endif

  assign bus.op_ready   = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.mul_start  = mul_start_reg;
  assign bus.mul_in_bus = mul_in_bus_reg;
  assign bus.res_valid  = res_valid_reg;
  assign bus.res_data   = res_data_reg;

  // Outputs are loaded on the edge entering a state so they are valid for that whole state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      mul_start_reg  <= 1'b0;
      mul_in_bus_reg <= '0;
      res_valid_reg  <= 1'b0;
      res_data_reg   <= '0;
`ifdef BOOTH_HOST_TIMEOUT_EN
      res_err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.op_valid) begin
            x_reg          <= bus.op_a;
            y_reg          <= bus.op_b;
            mul_start_reg  <= 1'b1;
            mul_in_bus_reg <= '0;
            state_reg      <= START;
          end
        end
        START: begin
          mul_start_reg  <= 1'b0;
          mul_in_bus_reg <= x_reg;
          state_reg      <= LOAD_X;
        end
        LOAD_X: begin
          mul_in_bus_reg <= y_reg;
          state_reg      <= LOAD_Y;
        end
        LOAD_Y: begin
          mul_in_bus_reg <= '0;
          state_reg      <= WAIT;
        end
        WAIT: begin
          // done is only meaningful here; stale pulses elsewhere fall through the other arms
          if (bus.mul_done) begin
            state_reg <= RD_HI;
          end else if (timeout) begin
            res_data_reg  <= '0;
            res_valid_reg <= 1'b1;
`ifdef BOOTH_HOST_TIMEOUT_EN
            res_err_reg   <= 1'b1;
`endif
            state_reg     <= RESP;
          end
        end
        RD_HI: begin
          res_data_reg[2*W-1:W] <= bus.mul_out_bus;
          state_reg             <= RD_LO;
        end
        RD_LO: begin
          res_data_reg[W-1:0] <= bus.mul_out_bus;
          res_valid_reg       <= 1'b1;
          state_reg           <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
`ifdef BOOTH_HOST_TIMEOUT_EN
            res_err_reg   <= 1'b0;
`endif
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_bus_host.sv
// Directed bench for booth_bus_host against a cycle-level BoothMultiplier bus model.
// Scoreboard holds expected products; BOOTH_HOST_TIMEOUT_EN adds the timeout scenario.
module tb_booth_bus_host;

  localparam int W = 6;
  localparam logic [W-1:0] GARBAGE = 6'h2A;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  booth_bus_host_if #(.W(W)) bus ();

  booth_bus_host #(
    .W(W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_cyc = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: samples start, then X, then Y, computes for m_lat+1 cycles,
  // pulses done for one cycle, then presents hi and lo on consecutive cycles.
  // It is deliberately not reset by rst, like the real block.
  typedef enum int {M_IDLE, M_X, M_Y, M_CALC, M_DONE, M_HI, M_LO} mst_t;
  mst_t           m_st = M_IDLE;
  logic           m_done = 1'b0;
  logic [W-1:0]   m_out = GARBAGE;
  logic [W-1:0]   m_x = '0;
  logic [W-1:0]   m_y = '0;
  logic [W-1:0]   m_start_bus = '0;
  logic [2*W-1:0] m_prod = '0;
  int             m_cnt = 0;
  int             m_start_cnt = 0;
  int             m_lat = 0;
  logic           mute = 1'b0;
  logic           inject = 1'b0;

  assign bus.mul_done    = (m_done & ~mute) | inject;
  assign bus.mul_out_bus = m_out;

  always @(posedge clk) begin
    case (m_st)
      M_IDLE: begin
        m_done <= 1'b0;
        m_out  <= GARBAGE;
        if (bus.mul_start) begin
          m_start_cnt <= 1;
          m_start_bus <= bus.mul_in_bus;
          m_st        <= M_X;
        end
      end
      M_X: begin
        m_x <= bus.mul_in_bus;
        if (bus.mul_start) m_start_cnt <= m_start_cnt + 1;
        m_st <= M_Y;
      end
      M_Y: begin
        m_y   <= bus.mul_in_bus;
        m_cnt <= m_lat;
        m_st  <= M_CALC;
      end
      M_CALC: begin
        if (m_cnt == 0) begin
          m_done <= 1'b1;
          m_prod <= {{W{m_x[W-1]}}, m_x} * {{W{m_y[W-1]}}, m_y};
          m_st   <= M_DONE;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      M_DONE: begin
        m_done <= 1'b0;
        m_out  <= m_prod[2*W-1:W];
        m_st   <= M_HI;
      end
      M_HI: begin
        m_out <= m_prod[W-1:0];
        m_st  <= M_LO;
      end
      default: begin
        m_out <= GARBAGE;
        m_st  <= M_IDLE;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   g;
    int   p;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    g = 0;
    while (bus.op_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("accept_wait_bounded", 32'(g < 100), 32'd1);
    @(posedge clk);
    #1;
    accept_cyc   = cyc;
    bus.op_valid = 1'b0;
    bus.op_a     = W'($urandom);
    bus.op_b     = W'($urandom);
    p = int'($signed(a)) * int'($signed(b));
    e.a    = a;
    e.b    = b;
    e.prod = p[2*W-1:0];
    sb.push_back(e);
  endtask

  // Latency is counted in edges from the accept edge to the edge that raises res_valid.
  task automatic get_result(input int exp_lat, input int hold, input bit exp_err);
    exp_t           e;
    int             g;
    bit             leak;
    bit             unstable;
    logic [2*W-1:0] d0;
    leak = 1'b0;
    g    = 0;
    @(negedge clk);
    while (bus.res_valid !== 1'b1 && g < 400) begin
      if (bus.op_ready !== 1'b0 || bus.busy !== 1'b1) leak = 1'b1;
      @(negedge clk);
      g++;
    end
    check("res_valid_seen", 32'(bus.res_valid), 32'd1);
    check("op_ready_low_during_op", 32'(leak), 32'd0);
    check("latency", 32'(cyc - accept_cyc), 32'(exp_lat));
    check("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (exp_err) begin
        check("timeout_data", 32'(bus.res_data), 32'd0);
      end else begin
        check("product", 32'(bus.res_data), 32'(e.prod));
        check("bus_x", 32'(m_x), 32'(e.a));
        check("bus_y", 32'(m_y), 32'(e.b));
        check("start_pulse_cycles", 32'(m_start_cnt), 32'd1);
        check("start_bus_zero", 32'(m_start_bus), 32'd0);
      end
`ifdef BOOTH_HOST_TIMEOUT_EN
      check("res_err_in_resp", 32'(bus.res_err), 32'(exp_err));
`endif
      $display("txn a=%0d b=%0d res_data=%h latency=%0d", $signed(e.a), $signed(e.b),
               bus.res_data, cyc - accept_cyc);
    end
    d0       = bus.res_data;
    unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.op_valid = 1'b1;
      bus.op_a     = W'($urandom);
      bus.op_b     = W'($urandom);
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== d0 || bus.mul_start !== 1'b0) unstable = 1'b1;
    end
    if (hold > 0) check("resp_hold_stable", 32'(unstable), 32'd0);
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("res_valid_cleared", 32'(bus.res_valid), 32'd0);
    check("idle_after_handshake", 32'(bus.op_ready), 32'd1);
`ifdef BOOTH_HOST_TIMEOUT_EN
    check("res_err_cleared", 32'(bus.res_err), 32'd0);
`endif
  endtask

  task automatic wait_model_idle(output bit busy_seen);
    int g;
    g = 0;
    busy_seen = 1'b0;
    while (m_st != M_IDLE && g < 100) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
      g++;
    end
    check("model_idle_bounded", 32'(g < 100), 32'd1);
  endtask

  initial begin
    bit busy_seen;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;

    // Reset values while rst is held low.
    repeat (3) @(negedge clk);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_mul_start", 32'(bus.mul_start), 32'd0);
    check("rst_mul_in_bus", 32'(bus.mul_in_bus), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("op_ready_after_reset", 32'(bus.op_ready), 32'd1);

    // 23 * -11 = -253 (12'hF03), with a 5-cycle RESP hold.
    m_lat = 3;
    send_op(6'b010111, 6'b110101);
    get_result(7 + 3, 5, 1'b0);

    // Back-to-back products with differing multiplier delays.
    m_lat = 0;
    send_op(6'd9, 6'd8);
    get_result(7 + 0, 0, 1'b0);
    m_lat = 1;
    send_op(6'b110110, 6'b101101);
    get_result(7 + 1, 0, 1'b0);
    m_lat = 5;
    send_op(6'd20, 6'd0);
    get_result(7 + 5, 0, 1'b0);

    // Spurious done during LOAD_X must not shorten the sequence.
    m_lat = 2;
    send_op(6'b111001, 6'd13);
    @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk);
    #1 inject = 1'b0;
    get_result(7 + 2, 0, 1'b0);

    // Reset while in WAIT; the multiplier's later done pulse must be ignored.
    m_lat = 20;
    send_op(6'd17, 6'b111101);
    repeat (4) @(negedge clk);
    check("in_wait_before_reset", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_mul_start", 32'(bus.mul_start), 32'd0);
    check("midrst_mul_in_bus", 32'(bus.mul_in_bus), 32'd0);
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_res_data", 32'(bus.res_data), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_op_ready", 32'(bus.op_ready), 32'd1);
    rst = 1'b1;
    void'(sb.pop_front());
    wait_model_idle(busy_seen);
    check("stale_done_ignored", 32'(busy_seen), 32'd0);

    // 31 * -32 = -992 (12'hC20) after the aborted operation.
    m_lat = 4;
    send_op(6'b011111, 6'b100000);
    get_result(7 + 4, 0, 1'b0);

`ifdef BOOTH_HOST_TIMEOUT_EN
    // done masked off: RESP after 8 WAIT cycles with zero data and res_err.
    mute  = 1'b1;
    m_lat = 20;
    send_op(6'd5, 6'd5);
    get_result(3 + 8, 0, 1'b1);
    wait_model_idle(busy_seen);
    check("timeout_stale_done_ignored", 32'(busy_seen), 32'd0);
    mute = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
